// File: rtl/coin_acceptor.sv
// Coin slot front end: synchronizes and debounces the slot sensor and issues
// one credit strobe and coin value per physical coin, rejecting invalid codes.
module coin_acceptor #(
  parameter int          DEB_CYCLES   = 4,
  parameter int          PULSE_CYCLES = 3,
  parameter logic [7:0]  VAL0         = 8'd5,
  parameter logic [7:0]  VAL1         = 8'd10,
  parameter logic [7:0]  VAL2         = 8'd25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_sense,
  input  logic [1:0] coin_code,
  output logic       c,
  output logic [7:0] a,
  output logic       reject,
  output logic [7:0] coin_count
);

  localparam int MAX_CNT = (DEB_CYCLES > PULSE_CYCLES) ? DEB_CYCLES : PULSE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_IN      = 3'd1,
    CREDIT      = 3'd2,
    REJECT      = 3'd3,
    WAIT_REMOVE = 3'd4,
    DEB_OUT     = 3'd5
  } state_t;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    logic [7:0] val;
    case (code)
      2'b00:   val = VAL0;
      2'b01:   val = VAL1;
      2'b10:   val = VAL2;
      default: val = 8'd0;
    endcase
    return val;
  endfunction

  logic          sense_meta_r, sense_s;
  logic [1:0]    code_meta_r, code_s;
  state_t        state_r, state_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s, pcnt_r, pcnt_nx_s;
  logic [1:0]    code_l_r, code_l_nx_s;
  logic          c_nx_s, reject_nx_s;
  logic [7:0]    a_nx_s, count_nx_s;

  // Two-flop synchronizers for the asynchronous slot inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sense_meta_r <= 1'b0;
      sense_s      <= 1'b0;
      code_meta_r  <= 2'b00;
      code_s       <= 2'b00;
    end else begin
      sense_meta_r <= coin_sense;
      sense_s      <= sense_meta_r;
      code_meta_r  <= coin_code;
      code_s       <= code_meta_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      pcnt_r     <= '0;
      code_l_r   <= 2'b00;
      c          <= 1'b0;
      a          <= 8'd0;
      reject     <= 1'b0;
      coin_count <= 8'd0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      pcnt_r     <= pcnt_nx_s;
      code_l_r   <= code_l_nx_s;
      c          <= c_nx_s;
      a          <= a_nx_s;
      reject     <= reject_nx_s;
      coin_count <= count_nx_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    pcnt_nx_s   = pcnt_r;
    code_l_nx_s = code_l_r;
    c_nx_s      = 1'b0;
    a_nx_s      = a;
    reject_nx_s = 1'b0;
    count_nx_s  = coin_count;
    case (state_r)
      IDLE: begin
        if (sense_s) begin
          state_nx_s  = DEB_IN;
          code_l_nx_s = code_s;
          cnt_nx_s    = CNT_ONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DEB_IN: begin
        if (!sense_s) begin
          state_nx_s = IDLE;
          cnt_nx_s   = '0;
        end else if (code_s != code_l_r) begin
          // A code change restarts the stability window before it can complete.
          code_l_nx_s = code_s;
          cnt_nx_s    = CNT_ONE;
        end else if (cnt_r == DEB_LAST) begin
          cnt_nx_s = '0;
          if (code_l_r == 2'b11) begin
            state_nx_s  = REJECT;
            reject_nx_s = 1'b1;
          end else begin
            state_nx_s = CREDIT;
            c_nx_s     = 1'b1;
            a_nx_s     = coin_value(code_l_r);
            count_nx_s = (coin_count == 8'hFF) ? 8'hFF : coin_count + 8'd1;
            pcnt_nx_s  = CNT_ONE;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      CREDIT: begin
        if (pcnt_r == PULSE_LAST) begin
          state_nx_s = WAIT_REMOVE;
          pcnt_nx_s  = '0;
        end else begin
          c_nx_s    = 1'b1;
          pcnt_nx_s = pcnt_r + CNT_ONE;
        end
      end
      REJECT: begin
        state_nx_s = WAIT_REMOVE;
      end
      WAIT_REMOVE: begin
        if (!sense_s) begin
          state_nx_s = DEB_OUT;
          cnt_nx_s   = CNT_ONE;
        end else begin
          state_nx_s = WAIT_REMOVE;
        end
      end
      DEB_OUT: begin
        if (sense_s) begin
          state_nx_s = WAIT_REMOVE;
          cnt_nx_s   = '0;
        end else if (cnt_r == DEB_LAST) begin
          state_nx_s = IDLE;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = '0;
        pcnt_nx_s  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: expected coin values are queued when a
// valid coin is driven and checked when the credit strobe rises.
module tb_coin_acceptor;

  localparam int PULSE = 3;
  localparam int LAT   = 6;

  logic       clk;
  logic       rst_n;
  logic       coin_sense;
  logic [1:0] coin_code;
  logic       c;
  logic [7:0] a;
  logic       reject;
  logic [7:0] coin_count;

  int n_cmp;
  int n_err;
  int c_rises;
  int r_rises;
  logic [7:0] exp_q[$];

  coin_acceptor dut (
    .clk(clk), .rst_n(rst_n), .coin_sense(coin_sense), .coin_code(coin_code),
    .c(c), .a(a), .reject(reject), .coin_count(coin_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on each credit, checks pulse widths.
  initial begin
    logic       c_prev, r_prev;
    int         c_len, r_len;
    logic [7:0] exp;
    c_prev = 1'b0; r_prev = 1'b0; c_len = 0; r_len = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        c_prev = 1'b0; r_prev = 1'b0; c_len = 0; r_len = 0;
      end else begin
        if (c === 1'b1 && !c_prev) begin
          c_rises++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL credit_unexpected: a=%0d, no credit expected", a);
          end else begin
            exp = exp_q.pop_front();
            if (a !== exp) begin
              n_err++;
              $display("FAIL credit_value: a=%0d required %0d", a, exp);
            end
          end
        end
        if (c === 1'b1) c_len++;
        else if (c_prev) begin
          n_cmp++;
          if (c_len != PULSE) begin
            n_err++;
            $display("FAIL c_width: %0d cycles required %0d", c_len, PULSE);
          end
          c_len = 0;
        end
        if (reject === 1'b1 && !r_prev) r_rises++;
        if (reject === 1'b1) r_len++;
        else if (r_prev) begin
          n_cmp++;
          if (r_len != 1) begin
            n_err++;
            $display("FAIL reject_width: %0d cycles required 1", r_len);
          end
          r_len = 0;
        end
        c_prev = c;
        r_prev = reject;
      end
    end
  end

  task automatic drive(input logic s, input logic [1:0] code, input int cycles);
    coin_sense = s;
    coin_code  = code;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic insert_measure(input logic [1:0] code, input int hold, output int lat);
    lat = 0;
    coin_sense = 1'b1;
    coin_code  = code;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (c === 1'b1 && lat == 0) lat = i;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    coin_sense = 1'b0;
    coin_code = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL reset_c: %b required 0", c); end
    n_cmp++; if (a !== 8'd0) begin n_err++; $display("FAIL reset_a: %0d required 0", a); end
    n_cmp++; if (reject !== 1'b0) begin n_err++; $display("FAIL reset_reject: %b required 0", reject); end
    n_cmp++; if (coin_count !== 8'd0) begin n_err++; $display("FAIL reset_count: %0d required 0", coin_count); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clean_nickel;
    int lat, r0;
    r0 = r_rises;
    exp_q.push_back(8'd5);
    insert_measure(2'b00, 20, lat);
    drive(1'b0, 2'b00, 20);
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL nickel_latency: %0d required %0d", lat, LAT); end
    n_cmp++; if (coin_count !== 8'd1) begin n_err++; $display("FAIL nickel_count: %0d required 1", coin_count); end
    n_cmp++; if (r_rises != r0) begin n_err++; $display("FAIL nickel_reject: %0d pulses required 0", r_rises - r0); end
  endtask

  task automatic test_bounce;
    int lat, c0;
    c0 = c_rises;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 2);
      drive(1'b0, 2'b00, 2);
    end
    drive(1'b0, 2'b00, 20);
    n_cmp++; if (c_rises != c0) begin n_err++; $display("FAIL bounce_credit: %0d pulses required 0", c_rises - c0); end
    n_cmp++; if (coin_count !== 8'd1) begin n_err++; $display("FAIL bounce_count: %0d required 1", coin_count); end
    exp_q.push_back(8'd10);
    insert_measure(2'b01, 20, lat);
    drive(1'b0, 2'b00, 20);
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL bounce_idle_latency: %0d required %0d", lat, LAT); end
  endtask

  task automatic test_invalid;
    int c0, r0;
    c0 = c_rises;
    r0 = r_rises;
    drive(1'b1, 2'b11, 15);
    drive(1'b0, 2'b00, 20);
    n_cmp++; if (r_rises != r0 + 1) begin n_err++; $display("FAIL invalid_reject: %0d pulses required 1", r_rises - r0); end
    n_cmp++; if (c_rises != c0) begin n_err++; $display("FAIL invalid_credit: %0d pulses required 0", c_rises - c0); end
    n_cmp++; if (a !== 8'd10) begin n_err++; $display("FAIL invalid_a: %0d required 10", a); end
    n_cmp++; if (coin_count !== 8'd2) begin n_err++; $display("FAIL invalid_count: %0d required 2", coin_count); end
    exp_q.push_back(8'd25);
    drive(1'b1, 2'b10, 15);
    drive(1'b0, 2'b00, 20);
    n_cmp++; if (a !== 8'd25) begin n_err++; $display("FAIL quarter_a: %0d required 25", a); end
    n_cmp++; if (coin_count !== 8'd3) begin n_err++; $display("FAIL quarter_count: %0d required 3", coin_count); end
  endtask

  task automatic test_code_change;
    int c0;
    c0 = c_rises;
    exp_q.push_back(8'd10);
    drive(1'b1, 2'b00, 3);
    drive(1'b1, 2'b01, 20);
    drive(1'b0, 2'b00, 20);
    n_cmp++; if (c_rises != c0 + 1) begin n_err++; $display("FAIL codechg_credits: %0d required 1", c_rises - c0); end
    n_cmp++; if (a !== 8'd10) begin n_err++; $display("FAIL codechg_a: %0d required 10", a); end
  endtask

  task automatic test_held_coin;
    int c0;
    c0 = c_rises;
    exp_q.push_back(8'd25);
    drive(1'b1, 2'b10, 100);
    n_cmp++; if (c_rises != c0 + 1) begin n_err++; $display("FAIL held_credits: %0d required 1", c_rises - c0); end
    drive(1'b0, 2'b10, 2);
    drive(1'b1, 2'b10, 30);
    drive(1'b0, 2'b00, 20);
    n_cmp++; if (c_rises != c0 + 1) begin n_err++; $display("FAIL glitch_credits: %0d required 1", c_rises - c0); end
    exp_q.push_back(8'd5);
    drive(1'b1, 2'b00, 15);
    drive(1'b0, 2'b00, 20);
    n_cmp++; if (c_rises != c0 + 2) begin n_err++; $display("FAIL second_coin_credits: %0d required 2", c_rises - c0); end
    n_cmp++; if (coin_count !== 8'd6) begin n_err++; $display("FAIL held_count: %0d required 6", coin_count); end
  endtask

  task automatic test_reset_mid_pulse;
    int lat;
    bit seen;
    seen = 1'b0;
    exp_q.push_back(8'd5);
    coin_sense = 1'b1;
    coin_code = 2'b00;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (c === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL midrst_credit: c=%b required 1 within 20 cycles", c); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL midrst_c: %b required 0", c); end
    n_cmp++; if (a !== 8'd0) begin n_err++; $display("FAIL midrst_a: %0d required 0", a); end
    n_cmp++; if (coin_count !== 8'd0) begin n_err++; $display("FAIL midrst_count: %0d required 0", coin_count); end
    n_cmp++; if (reject !== 1'b0) begin n_err++; $display("FAIL midrst_reject: %b required 0", reject); end
    coin_sense = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL midrst_idle_c: %b required 0", c); end
    exp_q.push_back(8'd10);
    insert_measure(2'b01, 15, lat);
    drive(1'b0, 2'b00, 20);
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL midrst_idle_latency: %0d required %0d", lat, LAT); end
    n_cmp++; if (coin_count !== 8'd1) begin n_err++; $display("FAIL midrst_count_after: %0d required 1", coin_count); end
  endtask

  task automatic test_saturation;
    test_reset();
    for (int i = 1; i <= 256; i++) begin
      exp_q.push_back(8'd10);
      drive(1'b1, 2'b01, 10);
      drive(1'b0, 2'b00, 10);
      if (i == 254) begin
        n_cmp++; if (coin_count !== 8'd254) begin n_err++; $display("FAIL sat_count_254: %0d required 254", coin_count); end
      end
    end
    n_cmp++; if (coin_count !== 8'd255) begin n_err++; $display("FAIL sat_count: %0d required 255", coin_count); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sat_pending: %0d credits outstanding required 0", exp_q.size()); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    c_rises = 0;
    r_rises = 0;
    rst_n = 1'b0;
    coin_sense = 1'b0;
    coin_code = 2'b00;
    test_reset();
    test_clean_nickel();
    test_bounce();
    test_invalid();
    test_code_change();
    test_held_coin();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL pending_credits: %0d outstanding required 0", exp_q.size()); end
    test_reset_mid_pulse();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
